sram_sum_ctrl: RTL



---
 rtl/sram_sum_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sram_sum_ctrl.sv
// sram_sum_ctrl -- scan-and-sum sequencer for a small asynchronous SRAM.
//
// On an accepted start it reads consecutive words from base_adr, one per
// clock, adding each word to a 16-bit sum until the terminator word appears.
// The sum is then written back, low byte first, to RESULT_ADR and
// RESULT_ADR+1. If 2^AW words are read without finding a terminator, the
// scan stops with err set and nothing is written. Every output comes
// straight from a flop, so the combinational SRAM always sees strobes that
// are stable for a full cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a scan (only honoured in IDLE)
//   base_adr  in   first address to read, latched on an accepted start
//   busy      out  high while reading or writing the result
//   done      out  one-cycle pulse at the end of every scan
//   err       out  scan ended without a terminator (held until next start)
//   sum       out  accumulated sum (held until next start)
//   count     out  number of non-terminator words summed
//   mem_adr   out  SRAM address
//   mem_rd    out  SRAM read strobe
//   mem_wr    out  SRAM write strobe (never high together with mem_rd)
//   mem_d     out  SRAM write data
//   mem_q     in   SRAM read data
module sram_sum_ctrl #(
  parameter int              AW         = 6,
  parameter int              DW         = 8,
  parameter int              SW         = 16,
  parameter logic [DW-1:0]   TERM       = 8'hFF,
  parameter int              RESULT_ADR = 60
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_adr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] sum,
  output logic [AW:0]   count,
  output logic [AW-1:0] mem_adr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] RES_LO   = AW'(RESULT_ADR);
  localparam logic [AW-1:0] RES_HI   = AW'(RESULT_ADR + 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADR_ZERO = AW'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  // Count value just before the last possible non-terminator word.
  localparam logic [AW:0]   CNT_LAST = (AW+1)'((2 ** AW) - 1);
  localparam logic [SW-1:0] SUM_ZERO = SW'(0);

  state_t          state_r, state_s;
  logic [AW-1:0]   ptr_r, ptr_s;
  logic [SW-1:0]   sum_s;
  logic [AW:0]     count_s;
  logic [AW-1:0]   adr_s;
  logic [DW-1:0]   d_s;
  logic            rd_s, wr_s, err_s, done_s, busy_s;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    sum_s   = sum;
    count_s = count;
    err_s   = err;
    adr_s   = mem_adr;
    rd_s    = mem_rd;
    wr_s    = mem_wr;
    d_s     = mem_d;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          ptr_s   = base_adr;
          sum_s   = SUM_ZERO;
          count_s = CNT_ZERO;
          err_s   = 1'b0;
          adr_s   = base_adr;
          rd_s    = 1'b1;
          wr_s    = 1'b0;
          state_s = READ;
        end else begin
          rd_s = 1'b0;
          wr_s = 1'b0;
        end
      end
      READ: begin
        if (mem_q == TERM) begin
          // Drop rd in the same edge that raises wr: the SRAM favours rd.
          rd_s    = 1'b0;
          wr_s    = 1'b1;
          adr_s   = RES_LO;
          d_s     = sum[DW-1:0];
          state_s = WR_LO;
        end else begin
          sum_s   = sum + SW'(mem_q);
          count_s = count + CNT_ONE;
          ptr_s   = ptr_r + PTR_ONE;
          adr_s   = ptr_r + PTR_ONE;
          if (count == CNT_LAST) begin
            // Whole memory read without a terminator: abort, no write-back.
            rd_s    = 1'b0;
            err_s   = 1'b1;
            state_s = DONE;
          end else begin
            rd_s = 1'b1;
          end
        end
      end
      WR_LO: begin
        adr_s   = RES_HI;
        d_s     = sum[DW +: DW];
        wr_s    = 1'b1;
        state_s = WR_HI;
      end
      WR_HI: begin
        wr_s    = 1'b0;
        adr_s   = ADR_ZERO;
        state_s = DONE;
      end
      DONE: begin
        // done is registered, so it is visible in the cycle after DONE.
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        rd_s    = 1'b0;
        wr_s    = 1'b0;
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == READ) || (state_s == WR_LO) || (state_s == WR_HI);
  end

  // State, pointer and registered outputs; reset clears strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= ADR_ZERO;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      sum     <= SUM_ZERO;
      count   <= CNT_ZERO;
      mem_adr <= ADR_ZERO;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      mem_d   <= DW'(0);
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      busy    <= busy_s;
      done    <= done_s;
      err     <= err_s;
      sum     <= sum_s;
      count   <= count_s;
      mem_adr <= adr_s;
      mem_rd  <= rd_s;
      mem_wr  <= wr_s;
      mem_d   <= d_s;
    end
  end

endmodule
